sentence_navigator: RTL and testbench

- Parametrised next-generation navigation controller for the predefined-message display mode.
- Tracks a sentence index and a word index, and presents the selected word to the 7-segment display path.
- Accepts button pulses, keyboard arrow scan codes and a timed auto-scroll, and drives the mode/position LEDs.
- Adds three things the previous generation lacked: configurable sentence/word counts, chained scrolling across sentence boundaries, and synchronous reset of all state.

---
 rtl/display_pkg.sv | 30 +++
 rtl/sentence_navigator_if.sv | 37 +++
 rtl/sentence_navigator_scroll_tick_gen.sv | 39 +++
 rtl/sentence_navigator.sv | 107 ++++++++++
 tb/tb_sentence_navigator.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared display-path definitions: keyboard scan codes, mode LED codes and the
// navigation event type used by the predefined-message navigator.
package display_pkg;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;

    localparam logic [1:0] MODE_PREDEF = 2'd2;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_SNEXT,
        EV_SPREV,
        EV_WNEXT,
        EV_WPREV
    } nav_event_t;

    // Only the highest-priority request survives: S+ > S- > W+ > W-.
    function automatic nav_event_t pick_event(input logic s_next, input logic s_prev,
                                              input logic w_next, input logic w_prev);
        if (s_next)      return EV_SNEXT;
        else if (s_prev) return EV_SPREV;
        else if (w_next) return EV_WNEXT;
        else if (w_prev) return EV_WPREV;
        else             return EV_NONE;
    endfunction

endpackage

// File: rtl/sentence_navigator_if.sv
// Navigation bus between the input/ROM side (master) and the navigator (slave).
interface sentence_navigator_if #(
    parameter int NUM_SENTENCES = 4,
    parameter int NUM_WORDS     = 8,
    parameter int WORD_W        = 32
);
    localparam int SW = (NUM_SENTENCES > 1) ? $clog2(NUM_SENTENCES) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic                        enable;
    logic [7:0]                  key_code;
    logic                        key_valid;
    logic                        next_sentence;
    logic                        prev_sentence;
    logic                        next_word;
    logic                        prev_word;
    logic                        auto_scroll;
    logic [NUM_WORDS*WORD_W-1:0] sentence;
    logic [WORD_W-1:0]           display_word;
    logic [SW-1:0]               sentence_idx;
    logic [WW-1:0]               word_idx;
    logic [NUM_SENTENCES-1:0]    sentence_onehot;
    logic [NUM_WORDS-1:0]        word_onehot;

    modport master (
        output enable, key_code, key_valid, next_sentence, prev_sentence,
               next_word, prev_word, auto_scroll, sentence,
        input  display_word, sentence_idx, word_idx, sentence_onehot, word_onehot
    );

    modport slave (
        input  enable, key_code, key_valid, next_sentence, prev_sentence,
               next_word, prev_word, auto_scroll, sentence,
        output display_word, sentence_idx, word_idx, sentence_onehot, word_onehot
    );

endinterface

// File: rtl/sentence_navigator_scroll_tick_gen.sv
// Auto-scroll timebase: one-cycle tick every SCROLL_COUNTS running cycles.
// SENTENCE_NAVIGATOR_PAUSE_ON_INPUT_EN: manual input restarts the period.
module scroll_tick_gen #(
    parameter int SCROLL_COUNTS = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    input  logic manual,
    output logic tick
);
    localparam int CW = (SCROLL_COUNTS > 1) ? $clog2(SCROLL_COUNTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCROLL_COUNTS - 1);

    logic [CW-1:0] count;
    logic          restart;

`ifdef SENTENCE_NAVIGATOR_PAUSE_ON_INPUT_EN
    assign restart = clear | manual;
`else
    logic unused_manual;
    assign unused_manual = manual;
    assign restart       = clear;
`endif

    assign tick = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/sentence_navigator.sv
// Predefined-message navigator: sentence/word indices, priority event decode,
// optional cross-sentence chaining and registered word selection for display.
module sentence_navigator
    import display_pkg::*;
#(
    parameter int NUM_SENTENCES = 4,
    parameter int NUM_WORDS     = 8,
    parameter int WORD_W        = 32,
    parameter int SCROLL_COUNTS = 100_000_000,
    parameter int CHAIN         = 1
) (
    input logic             clk,
    input logic             reset_n,
    sentence_navigator_if.slave nav
);
    localparam int SW = (NUM_SENTENCES > 1) ? $clog2(NUM_SENTENCES) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(NUM_SENTENCES - 1);
    localparam logic [WW-1:0] W_LAST = WW'(NUM_WORDS - 1);

    logic [SW-1:0]     sentence_q, sentence_d, sentence_inc, sentence_dec;
    logic [WW-1:0]     word_q, word_d;
    logic [WORD_W-1:0] display_q;
    logic              s_next, s_prev, w_next, w_prev, manual_event, tick;
    nav_event_t        ev;

    always_comb begin
        s_next = nav.next_sentence | (nav.key_valid && nav.key_code == KEY_UP);
        s_prev = nav.prev_sentence | (nav.key_valid && nav.key_code == KEY_DOWN);
        w_next = nav.next_word     | (nav.key_valid && nav.key_code == KEY_RIGHT);
        w_prev = nav.prev_word     | (nav.key_valid && nav.key_code == KEY_LEFT);
        manual_event = nav.enable && (s_next | s_prev | w_next | w_prev);
        ev = nav.enable ? pick_event(s_next, s_prev, w_next | tick, w_prev) : EV_NONE;
    end

    scroll_tick_gen #(
        .SCROLL_COUNTS(SCROLL_COUNTS)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (nav.enable && nav.auto_scroll),
        .clear  (!nav.auto_scroll),
        .manual (manual_event),
        .tick   (tick)
    );

    // Explicit compare-and-wrap keeps non-power-of-two counts correct.
    always_comb begin
        sentence_inc = (sentence_q == S_LAST) ? '0 : sentence_q + SW'(1);
        sentence_dec = (sentence_q == '0) ? S_LAST : sentence_q - SW'(1);
        sentence_d   = sentence_q;
        word_d       = word_q;
        unique case (ev)
            EV_SNEXT: begin
                sentence_d = sentence_inc;
                word_d     = '0;
            end
            EV_SPREV: begin
                sentence_d = sentence_dec;
                word_d     = '0;
            end
            EV_WNEXT: begin
                if (word_q == W_LAST) begin
                    word_d = '0;
                    if (CHAIN != 0) sentence_d = sentence_inc;
                end else begin
                    word_d = word_q + WW'(1);
                end
            end
            EV_WPREV: begin
                if (word_q == '0) begin
                    word_d = W_LAST;
                    if (CHAIN != 0) sentence_d = sentence_dec;
                end else begin
                    word_d = word_q - WW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sentence_q <= '0;
            word_q     <= '0;
            display_q  <= '0;
        end else begin
            sentence_q <= sentence_d;
            word_q     <= word_d;
            display_q  <= nav.sentence[(NUM_WORDS - 1 - int'(word_q)) * WORD_W +: WORD_W];
        end
    end

    always_comb begin
        nav.sentence_onehot = '0;
        nav.word_onehot     = '0;
        for (int i = 0; i < NUM_SENTENCES; i++)
            nav.sentence_onehot[i] = (sentence_q == SW'(NUM_SENTENCES - 1 - i));
        for (int i = 0; i < NUM_WORDS; i++)
            nav.word_onehot[i] = (word_q == WW'(NUM_WORDS - 1 - i));
    end

    assign nav.sentence_idx = sentence_q;
    assign nav.word_idx     = word_q;
    assign nav.display_word = display_q;

endmodule

// File: tb/tb_sentence_navigator.sv
// Directed bench for sentence_navigator: a CHAIN=1 and a CHAIN=0 instance share
// the same stimulus; SCROLL_COUNTS is shortened to 10 for the auto-scroll cases.
module tb_sentence_navigator;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    sentence_navigator_if #(.NUM_SENTENCES(4), .NUM_WORDS(8), .WORD_W(32)) nav_a ();
    sentence_navigator_if #(.NUM_SENTENCES(4), .NUM_WORDS(8), .WORD_W(32)) nav_b ();

    sentence_navigator #(
        .NUM_SENTENCES(4), .NUM_WORDS(8), .WORD_W(32), .SCROLL_COUNTS(10), .CHAIN(1)
    ) dut_chain (
        .clk(clk), .reset_n(reset_n), .nav(nav_a)
    );

    sentence_navigator #(
        .NUM_SENTENCES(4), .NUM_WORDS(8), .WORD_W(32), .SCROLL_COUNTS(10), .CHAIN(0)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .nav(nav_b)
    );

    assign nav_b.enable        = nav_a.enable;
    assign nav_b.key_code      = nav_a.key_code;
    assign nav_b.key_valid     = nav_a.key_valid;
    assign nav_b.next_sentence = nav_a.next_sentence;
    assign nav_b.prev_sentence = nav_a.prev_sentence;
    assign nav_b.next_word     = nav_a.next_word;
    assign nav_b.prev_word     = nav_a.prev_word;
    assign nav_b.auto_scroll   = nav_a.auto_scroll;
    assign nav_b.sentence      = nav_a.sentence;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ns;
        logic       ps;
        logic       nw;
        logic       pw;
        logic       kv;
        logic [7:0] kc;
        int         s1;
        int         w1;
        int         s0;
        int         w0;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idx(input string tag, input int s1, input int w1, input int s0, input int w0);
        logic [3:0] soh;
        logic [7:0] woh;
        soh = 4'b1000;
        woh = 8'b1000_0000;
        check({tag, " chain sentence_idx"}, 64'(nav_a.sentence_idx), 64'(s1));
        check({tag, " chain word_idx"},     64'(nav_a.word_idx),     64'(w1));
        check({tag, " wrap sentence_idx"},  64'(nav_b.sentence_idx), 64'(s0));
        check({tag, " wrap word_idx"},      64'(nav_b.word_idx),     64'(w0));
        check({tag, " sentence_onehot"},    64'(nav_a.sentence_onehot), 64'(soh >> s1));
        check({tag, " word_onehot"},        64'(nav_a.word_onehot),     64'(woh >> w1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        nav_a.next_sentence = 1'b0;
        nav_a.prev_sentence = 1'b0;
        nav_a.next_word     = 1'b0;
        nav_a.prev_word     = 1'b0;
        nav_a.key_valid     = 1'b0;
        nav_a.key_code      = 8'h00;
    endtask

    task automatic applyStimulus(input vec_t v);
        nav_a.enable        = v.en;
        nav_a.next_sentence = v.ns;
        nav_a.prev_sentence = v.ps;
        nav_a.next_word     = v.nw;
        nav_a.prev_word     = v.pw;
        nav_a.key_valid     = v.kv;
        nav_a.key_code      = v.kc;
        step();
        clear_inputs();
        nav_a.enable = 1'b1;
    endtask

    task automatic pulse(input logic ns, input logic ps, input logic nw, input logic pw);
        nav_a.next_sentence = ns;
        nav_a.prev_sentence = ps;
        nav_a.next_word     = nw;
        nav_a.prev_word     = pw;
        step();
        clear_inputs();
    endtask

    initial begin
        logic [255:0] sent;
        int exp_w;
        int second_tick;

        errors = 0;
        checks = 0;
        for (int i = 0; i < 8; i++) sent[(7 - i) * 32 +: 32] = 32'hA000_0000 + 32'(i);
        sent[(7 - 3) * 32 +: 32] = 32'hDEAD_BEEF;
        nav_a.sentence    = sent;
        nav_a.enable      = 1'b1;
        nav_a.auto_scroll = 1'b0;
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        check("reset display_word", 64'(nav_a.display_word), 64'h0);
        check_idx("reset", 0, 0, 0, 0);
        reset_n = 1'b1;

        //                en ns ps nw pw kv kc      s1 w1 s0 w0
        for (int i = 0; i < 7; i++) vecs[i] = '{1, 0, 0, 1, 0, 0, 8'h00, 0, i + 1, 0, i + 1};
        vecs[7]  = '{1, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 1, 0, 8'h00, 0, 7, 0, 7};
        vecs[9]  = '{1, 0, 1, 0, 0, 0, 8'h00, 3, 0, 3, 0};
        vecs[10] = '{1, 0, 0, 0, 0, 1, 8'h75, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1};
        vecs[12] = '{1, 0, 0, 1, 0, 0, 8'h00, 0, 2, 0, 2};
        vecs[13] = '{1, 0, 0, 1, 0, 0, 8'h00, 0, 3, 0, 3};
        vecs[14] = '{1, 1, 0, 1, 0, 0, 8'h00, 1, 0, 1, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 1, 8'h74, 1, 1, 1, 1};
        vecs[16] = '{1, 0, 0, 0, 0, 1, 8'h6B, 1, 0, 1, 0};
        vecs[17] = '{1, 0, 0, 0, 0, 1, 8'h72, 0, 0, 0, 0};
        vecs[18] = '{0, 1, 1, 1, 1, 1, 8'h75, 0, 0, 0, 0};
        vecs[19] = '{1, 0, 1, 1, 1, 0, 8'h00, 3, 0, 3, 0};
        vecs[20] = '{1, 0, 0, 1, 1, 0, 8'h00, 3, 1, 3, 1};
        vecs[21] = '{1, 0, 0, 0, 0, 1, 8'h11, 3, 1, 3, 1};
        vecs[22] = '{1, 0, 0, 0, 0, 0, 8'h75, 3, 1, 3, 1};
        vecs[23] = '{1, 0, 0, 0, 1, 0, 8'h00, 3, 0, 3, 0};
        vecs[24] = '{1, 0, 0, 0, 1, 0, 8'h00, 2, 7, 3, 7};

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i]);
            check_idx($sformatf("vec%0d", i), vecs[i].s1, vecs[i].w1, vecs[i].s0, vecs[i].w0);
        end

        // Reset from a non-zero position.
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) pulse(0, 0, 1, 0);
        check_idx("pre-reset", 2, 5, 3, 5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_idx("post-reset", 0, 0, 0, 0);
        check("post-reset display_word", 64'(nav_a.display_word), 64'h0);

        // Display latency: word index leads display_word by one cycle.
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        check("display lags word_idx", 64'(nav_a.display_word), 64'hA000_0002);
        check_idx("at word 3", 0, 3, 0, 3);
        step();
        check("display word 3", 64'(nav_a.display_word), 64'hDEAD_BEEF);

        // Disabled: navigation frozen, display still follows the sentence bus.
        nav_a.enable = 1'b0;
        sent[(7 - 3) * 32 +: 32] = 32'h1234_5678;
        nav_a.sentence = sent;
        applyStimulus('{0, 1, 1, 1, 1, 1, 8'h74, 0, 3, 0, 3});
        check_idx("disabled", 0, 3, 0, 3);
        check("disabled display tracks", 64'(nav_a.display_word), 64'h1234_5678);

        // Auto-scroll from word 3; a manual next_word lands on edge 15.
`ifdef SENTENCE_NAVIGATOR_PAUSE_ON_INPUT_EN
        second_tick = 25;
`else
        second_tick = 20;
`endif
        nav_a.auto_scroll = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            if (k == 15) nav_a.next_word = 1'b1;
            step();
            nav_a.next_word = 1'b0;
            exp_w = 3 + ((k >= 10) ? 1 : 0) + ((k >= 15) ? 1 : 0) + ((k >= second_tick) ? 1 : 0);
            if (k == 9 || k == 10 || k == 14 || k == 15 || k == 19 || k == 20 || k == 24 || k == 25)
                check_idx($sformatf("scroll edge %0d", k), 0, exp_w, 0, exp_w);
        end
        nav_a.auto_scroll = 1'b0;
        step();

        // Reset while a tick is pending restarts the period.
        nav_a.auto_scroll = 1'b1;
        for (int k = 1; k <= 9; k++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_idx("reset mid-scroll", 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) step();
        check_idx("post-reset scroll 9", 0, 0, 0, 0);
        step();
        check_idx("post-reset scroll 10", 0, 1, 0, 1);
        nav_a.auto_scroll = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
